wb_register_file: RTL and testbench
===================================

# wb_register_file

Writeback stage and general-purpose register file of the 5-stage MIPS pipeline, sitting at the far end of the MEM/WB register. It selects the writeback value (memory load data or ALU result) and commits it to a 32-entry register file on the clock edge. The same block serves the two ID-stage read ports, with same-cycle write-to-read bypass so a value written back is visible to the instruction being decoded in that cycle.

## Interface
- DATA_WIDTH, 32: register and datapath width.
- ADDR_WIDTH, 5: register address width; depth = 2**ADDR_WIDTH.
- BYPASS_EN, 1: 1 = WB-to-ID same-cycle bypass on read ports; 0 = reads return stored contents only.

- clk  in  1  pipeline clock; all writes on rising edge.
- rst  in  1  asynchronous reset, active-high; clears every register.
- read_data_wb  in  DATA_WIDTH  load data from MEM/WB.
- alu_result_wb  in  DATA_WIDTH  ALU result from MEM/WB.
- write_reg_addr_wb  in  ADDR_WIDTH  destination register from MEM/WB.
- ctrl_MemToReg_wb  in  1  1 = write read_data_wb, 0 = write alu_result_wb.
- ctrl_RegWrite_wb  in  1  write enable for the writeback.
- read_addr1  in  ADDR_WIDTH  ID-stage source register rs.
- read_addr2  in  ADDR_WIDTH  ID-stage source register rt.
- read_data1  out  DATA_WIDTH  contents of read_addr1.
- read_data2  out  DATA_WIDTH  contents of read_addr2.
- write_back_data  out  DATA_WIDTH  selected writeback value, also routed to EX forwarding.

## Operation
- write_back_data = ctrl_MemToReg_wb ? read_data_wb : alu_result_wb; purely combinational, independent of rst and ctrl_RegWrite_wb.
- Write commit: on rising clk with rst = 0, ctrl_RegWrite_wb = 1 and write_reg_addr_wb != 0, regs[write_reg_addr_wb] <= write_back_data.
- Register 0 is hardwired zero: writes to address 0 are discarded; reads of address 0 always return 0, including when bypass would match.
- Read ports combinational, independent of each other; both ports may address the same register.
- Bypass (BYPASS_EN = 1): if ctrl_RegWrite_wb = 1, write_reg_addr_wb != 0 and read_addrN == write_reg_addr_wb, read_dataN = write_back_data; otherwise read_dataN = regs[read_addrN]. Both ports bypass independently.
- BYPASS_EN = 0: read_dataN = regs[read_addrN]; new value visible only after the committing edge.
- No stall input: the MEM/WB register holds its outputs during stalls, so a repeated write of the same value is harmless and required to be idempotent.

## Timing
- Reset: rst high clears all registers immediately, no clock needed; read_data1/2 = 0 while rst = 1 (bypass suppressed during reset); write_back_data still follows the mux.
- Writes on a clk edge with rst = 1 are ignored; rst deasserted mid-stream leaves all registers 0, first write on the next qualifying edge.
- Write latency: 1 cycle to storage; 0 cycles to read ports with bypass enabled.
- Back-to-back writes to the same register: the last edge wins; the bypassed value always reflects the current MEM/WB inputs, never the stale stored value.
- Simultaneous write and read of different registers: read returns stored value, unaffected.

## Test plan
- Reset: preload regs 1..31 with 32'h1111_0000+i, assert rst between edges -> read_data1/2 = 0 for every address immediately, stays 0 after rst falls until new writes.
- ALU writeback: MemToReg = 0, alu_result_wb = 32'hCAFEBABE, addr 15, RegWrite = 1, one edge -> read_addr1 = 15 returns CAFEBABE; write_back_data = CAFEBABE.
- Load writeback plus bypass: MemToReg = 1, read_data_wb = 32'hDEADBEEF, addr 7, read_addr1 = read_addr2 = 7 before the edge -> both ports return DEADBEEF in the same cycle (BYPASS_EN = 1), stored after edge; with BYPASS_EN = 0 -> old value until the edge.
- Register zero: write 32'hFFFFFFFF to addr 0 with RegWrite = 1, read_addr1 = 0 -> read_data1 = 0 both before and after the edge.
- Write disabled: RegWrite = 0, addr 15, alu_result_wb = 32'hBBBBBBBB -> reg 15 keeps CAFEBABE, no bypass; write_back_data = BBBBBBBB.
- Back-to-back: writes 32'h1 then 32'h2 to addr 3 on consecutive edges, read_addr2 = 3 -> reads 1 (bypass) then 2 (bypass), reg 3 = 2 after second edge.

Source files
------------

// File: rtl/wb_register_file.sv
// Writeback mux and 32-entry GPR file for the MIPS pipeline.
// Two combinational read ports with optional same-cycle WB-to-ID bypass.
module wb_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit BYPASS_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] read_data_wb,
   input  logic [DATA_WIDTH-1:0] alu_result_wb,
   input  logic [ADDR_WIDTH-1:0] write_reg_addr_wb,
   input  logic                  ctrl_MemToReg_wb,
   input  logic                  ctrl_RegWrite_wb,
   input  logic [ADDR_WIDTH-1:0] read_addr1,
   input  logic [ADDR_WIDTH-1:0] read_addr2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   output logic [DATA_WIDTH-1:0] write_back_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic                  write_en;

   assign write_back_data = ctrl_MemToReg_wb ? read_data_wb : alu_result_wb;

   // Register 0 never takes a write, so it stays at its reset value of zero.
   assign write_en = ctrl_RegWrite_wb && (write_reg_addr_wb != '0);

   always_comb begin
      regs_d = regs_q;
      if (write_en) begin
         regs_d[write_reg_addr_wb] = write_back_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reset forces both ports to zero even while a bypass would match.
   always_comb begin
      read_data1 = regs_q[read_addr1];
      if (rst || (read_addr1 == '0)) begin
         read_data1 = '0;
      end else if (BYPASS_EN && write_en && (read_addr1 == write_reg_addr_wb)) begin
         read_data1 = write_back_data;
      end
   end

   always_comb begin
      read_data2 = regs_q[read_addr2];
      if (rst || (read_addr2 == '0)) begin
         read_data2 = '0;
      end else if (BYPASS_EN && write_en && (read_addr2 == write_reg_addr_wb)) begin
         read_data2 = write_back_data;
      end
   end

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file: one bypassing and one non-bypassing
// instance share all inputs so both read-port behaviours are checked per vector.
module tb_wb_register_file;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] read_data_wb = '0;
   logic [31:0] alu_result_wb = '0;
   logic [4:0]  write_reg_addr_wb = '0;
   logic        ctrl_MemToReg_wb = 1'b0;
   logic        ctrl_RegWrite_wb = 1'b0;
   logic [4:0]  read_addr1 = '0;
   logic [4:0]  read_addr2 = '0;
   logic [31:0] read_data1, read_data2, write_back_data;
   logic [31:0] nb_read_data1, nb_read_data2, nb_write_back_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .read_data_wb(read_data_wb), .alu_result_wb(alu_result_wb),
      .write_reg_addr_wb(write_reg_addr_wb),
      .ctrl_MemToReg_wb(ctrl_MemToReg_wb), .ctrl_RegWrite_wb(ctrl_RegWrite_wb),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(read_data1), .read_data2(read_data2),
      .write_back_data(write_back_data)
   );

   wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) dut_nb (
      .clk(clk), .rst(rst),
      .read_data_wb(read_data_wb), .alu_result_wb(alu_result_wb),
      .write_reg_addr_wb(write_reg_addr_wb),
      .ctrl_MemToReg_wb(ctrl_MemToReg_wb), .ctrl_RegWrite_wb(ctrl_RegWrite_wb),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(nb_read_data1), .read_data2(nb_read_data2),
      .write_back_data(nb_write_back_data)
   );

   typedef struct {
      logic        mtr;
      logic        we;
      logic [31:0] rdwb;
      logic [31:0] alu;
      logic [4:0]  waddr;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic [31:0] e_nb1;
      logic [31:0] e_nb2;
      logic [31:0] e_wbd;
   } vec_t;

   vec_t vecs [14];

   task automatic applyStimulus(input logic mtr, input logic we, input logic [31:0] rdwb,
                                input logic [31:0] alu, input logic [4:0] waddr,
                                input logic [4:0] ra1, input logic [4:0] ra2);
      ctrl_MemToReg_wb  = mtr;
      ctrl_RegWrite_wb  = we;
      read_data_wb      = rdwb;
      alu_result_wb     = alu;
      write_reg_addr_wb = waddr;
      read_addr1        = ra1;
      read_addr2        = ra2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Both instances must agree here: reads of stored contents only.
   task automatic checkStoredPair(input string name, input logic [31:0] e1, input logic [31:0] e2);
      checkOutput({name, " rd1"}, read_data1, e1);
      checkOutput({name, " rd2"}, read_data2, e2);
      checkOutput({name, " nb rd1"}, nb_read_data1, e1);
      checkOutput({name, " nb rd2"}, nb_read_data2, e2);
   endtask

   initial begin
      // Reset state at time zero
      #1;
      checkStoredPair("reset t0", 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Preload regs 1..31 with 32'h1111_0000 + i
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b0, 1'b1, 32'h0, 32'h1111_0000 + i, 5'(i), 5'd0, 5'd0);
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
      #1;
      checkStoredPair("preload", 32'h1111_0001, 32'h1111_001F);

      // Asynchronous reset between edges clears every register immediately
      rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         read_addr1 = 5'(i);
         read_addr2 = 5'(31 - i);
         #1;
         checkStoredPair($sformatf("in reset a%0d", i), 32'h0, 32'h0);
      end

      // Write attempted during reset: no bypass, no commit, mux still live
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_0077, 5'd5, 5'd5, 5'd5);
      #1;
      checkStoredPair("reset bypass", 32'h0, 32'h0);
      checkOutput("reset wbd", write_back_data, 32'h0000_0077);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         read_addr1 = 5'(i);
         read_addr2 = 5'(31 - i);
         #1;
         checkStoredPair($sformatf("post reset a%0d", i), 32'h0, 32'h0);
      end

      // Vector table: fields mtr, we, rdwb, alu, waddr, ra1, ra2, rd1, rd2, nb1, nb2, wbd
      vecs[0]  = '{1'b0, 1'b1, 32'h1234_5678, 32'hCAFE_BABE, 5'd15, 5'd15, 5'd0,
                   32'hCAFE_BABE, 32'h0, 32'h0, 32'h0, 32'hCAFE_BABE};
      vecs[1]  = '{1'b0, 1'b0, 32'h5555_5555, 32'h0, 5'd15, 5'd15, 5'd15,
                   32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'h0};
      vecs[2]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h9999_9999, 5'd7, 5'd7, 5'd7,
                   32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd15,
                   32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd7,
                   32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
      vecs[5]  = '{1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5};
      vecs[6]  = '{1'b0, 1'b0, 32'h0, 32'hBBBB_BBBB, 5'd15, 5'd15, 5'd7,
                   32'hCAFE_BABE, 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'hBBBB_BBBB};
      vecs[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd15, 5'd0,
                   32'hCAFE_BABE, 32'h0, 32'hCAFE_BABE, 32'h0, 32'h0};
      vecs[8]  = '{1'b0, 1'b1, 32'h0, 32'h0000_0001, 5'd3, 5'd15, 5'd3,
                   32'hCAFE_BABE, 32'h0000_0001, 32'hCAFE_BABE, 32'h0, 32'h0000_0001};
      vecs[9]  = '{1'b0, 1'b1, 32'h0, 32'h0000_0002, 5'd3, 5'd3, 5'd3,
                   32'h0000_0002, 32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
      vecs[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd7,
                   32'h0000_0002, 32'hDEAD_BEEF, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0};
      vecs[11] = '{1'b1, 1'b1, 32'h4444_4444, 32'h0, 5'd9, 5'd3, 5'd15,
                   32'h0000_0002, 32'hCAFE_BABE, 32'h0000_0002, 32'hCAFE_BABE, 32'h4444_4444};
      vecs[12] = '{1'b1, 1'b1, 32'h4444_4444, 32'h0, 5'd9, 5'd9, 5'd9,
                   32'h4444_4444, 32'h4444_4444, 32'h4444_4444, 32'h4444_4444, 32'h4444_4444};
      vecs[13] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9, 5'd3,
                   32'h4444_4444, 32'h0000_0002, 32'h4444_4444, 32'h0000_0002, 32'h0};

      // Each vector is checked combinationally, then committed by the next rising edge
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].mtr, vecs[i].we, vecs[i].rdwb, vecs[i].alu,
                       vecs[i].waddr, vecs[i].ra1, vecs[i].ra2);
         #1;
         checkOutput($sformatf("v%0d rd1", i), read_data1, vecs[i].e_rd1);
         checkOutput($sformatf("v%0d rd2", i), read_data2, vecs[i].e_rd2);
         checkOutput($sformatf("v%0d nb rd1", i), nb_read_data1, vecs[i].e_nb1);
         checkOutput($sformatf("v%0d nb rd2", i), nb_read_data2, vecs[i].e_nb2);
         checkOutput($sformatf("v%0d wbd", i), write_back_data, vecs[i].e_wbd);
      end

      // Register zero after the discarded write, plus final state of the others
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd15);
      #1;
      checkStoredPair("final r0/r15", 32'h0, 32'hCAFE_BABE);
      read_addr1 = 5'd3;
      read_addr2 = 5'd1;
      #1;
      checkStoredPair("final r3/r1", 32'h0000_0002, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
